// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into little-endian 32-bit
// words and writes them to instruction memory from BASE_ADDR upward.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin a load (only honoured in IDLE)
//   len_words     words to load, clamped to DEPTH_WORDS, latched on start
//   byte_valid    byte_data holds a valid byte
//   byte_data     stream byte; first byte of a word lands in [7:0]
//   byte_ready    loader accepts a byte (transfer = byte_valid & byte_ready)
//   mem_we        one-cycle write strobe to instruction memory
//   mem_addr      registered byte address of the write
//   mem_wdata     registered assembled word
//   busy          load in progress
//   core_hold     same as busy; keeps the pipeline in reset
//   done          one-cycle pulse at the end of a load
//   checksum      running sum of written words, or 0 (see below)
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.

module imem_loader #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LW          = $clog2(DEPTH_WORDS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len_words,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          core_hold,
    output logic          done,
    output logic [31:0]   checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [LW-1:0] DepthC = LW'(DEPTH_WORDS);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   buf_q, buf_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [LW-1:0] len_clamp;
    logic [LW-1:0] word_idx_inc;
    logic [31:0]   word_off;

    assign len_clamp    = (len_words > DepthC) ? DepthC : len_words;
    assign word_idx_inc = word_idx_q + 1'b1;
    assign word_off     = 32'(word_idx_q) << 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len_clamp;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    buf_d      = '0;
                    state_d    = (len_clamp == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                // byte_ready is high here, so byte_valid alone is a transfer
                if (byte_valid) begin
                    buf_d[8*byte_idx_q +: 8] = byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Load the output registers now so the word is
                        // presented during the single WRITE cycle.
                        state_d = S_WRITE;
                        addr_d  = BASE_ADDR + word_off;
                        wdata_d = {byte_data, buf_q[23:0]};
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == len_q) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_ready = (state_q == S_COLLECT);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign core_hold  = busy;
    assign done       = (state_q == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        sum_clr;

    assign sum_clr = (state_q == S_IDLE) && start;

    always_comb begin
        sum_d = sum_q;
        if (sum_clr) begin
            sum_d = '0;
        end else if (state_q == S_WRITE) begin
            sum_d = sum_q + wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
